m_wb_arbiter2: RTL and testbench

- Two-master to one-slave Wishbone classic arbiter. It lets the midgetv core (master 0) and a second master (master 1: loader or DMA engine) share the on-chip wishbone slave set (simple/dynamic wishbone registers and similar peripherals).
- Grant is round-robin on contention and is held for a whole CYC bus cycle.
- A bus watchdog terminates transfers the addressed slave never acknowledges, so an unmapped address cannot hang a master.

---
 rtl/m_wb_arbiter2.sv | 132 +++++++++++++
 tb/tb_m_wb_arbiter2.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_wb_arbiter2.sv
// Two-master to one-slave Wishbone classic arbiter with round-robin grant held per CYC
// and a bus watchdog that acknowledges accesses the slave never answers.
module m_wb_arbiter2 #(
    parameter int          TIMEOUT = 64,
    parameter logic [31:0] TOVAL   = 32'hDEADBEEF,
    parameter int          TOW     = 7
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        M0_CYC_I,
    input  logic        M0_STB_I,
    input  logic        M0_WE_I,
    input  logic [31:0] M0_ADR_I,
    input  logic [31:0] M0_DAT_I,
    input  logic [3:0]  M0_SEL_I,
    output logic        M0_ACK_O,
    output logic [31:0] M0_DAT_O,
    input  logic        M1_CYC_I,
    input  logic        M1_STB_I,
    input  logic        M1_WE_I,
    input  logic [31:0] M1_ADR_I,
    input  logic [31:0] M1_DAT_I,
    input  logic [3:0]  M1_SEL_I,
    output logic        M1_ACK_O,
    output logic [31:0] M1_DAT_O,
    output logic        CYC_O,
    output logic        STB_O,
    output logic        WE_O,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    input  logic        ACK_I,
    input  logic [31:0] DAT_I,
    output logic [1:0]  gnt,
    output logic        timeout
);

    // Handshake: a beat completes in the cycle the owner's STB_O and ACK_I (or a
    // watchdog hit) are both high; the grant itself only moves when the owner drops CYC.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [TOW-1:0]   cnt_q, cnt_d;
    logic             own0, own1, stb_raw, hit;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (M0_CYC_I && M1_CYC_I) state_d = last_q ? GNT0 : GNT1;
                else if (M0_CYC_I)        state_d = GNT0;
                else if (M1_CYC_I)        state_d = GNT1;
            end
            GNT0: begin
                if (!M0_CYC_I) begin
                    last_d  = 1'b0;
                    state_d = M1_CYC_I ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!M1_CYC_I) begin
                    last_d  = 1'b1;
                    state_d = M0_CYC_I ? GNT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        own0    = (state_q == GNT0);
        own1    = (state_q == GNT1);
        stb_raw = (own0 && M0_STB_I) || (own1 && M1_STB_I);
        // ACK_I has priority over a watchdog hit landing in the same cycle.
        hit     = (TIMEOUT != 0) && stb_raw && !ACK_I && (cnt_q == TOW'(TIMEOUT));

        if ((state_d != state_q) || !stb_raw || ACK_I || hit) cnt_d = '0;
        else if (cnt_q != {TOW{1'b1}})                         cnt_d = cnt_q + TOW'(1);
        else                                                   cnt_d = cnt_q;

        CYC_O    = 1'b0;
        STB_O    = 1'b0;
        WE_O     = 1'b0;
        ADR_O    = '0;
        DAT_O    = '0;
        SEL_O    = '0;
        M0_ACK_O = 1'b0;
        M0_DAT_O = '0;
        M1_ACK_O = 1'b0;
        M1_DAT_O = '0;
        if (own0) begin
            CYC_O    = M0_CYC_I;
            STB_O    = M0_STB_I && !hit;
            WE_O     = M0_WE_I;
            ADR_O    = M0_ADR_I;
            DAT_O    = M0_DAT_I;
            SEL_O    = M0_SEL_I;
            M0_ACK_O = ACK_I || hit;
            M0_DAT_O = hit ? TOVAL : DAT_I;
        end else if (own1) begin
            CYC_O    = M1_CYC_I;
            STB_O    = M1_STB_I && !hit;
            WE_O     = M1_WE_I;
            ADR_O    = M1_ADR_I;
            DAT_O    = M1_DAT_I;
            SEL_O    = M1_SEL_I;
            M1_ACK_O = ACK_I || hit;
            M1_DAT_O = hit ? TOVAL : DAT_I;
        end
        timeout = hit;
        gnt     = state_q;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_m_wb_arbiter2.sv
// Bench for m_wb_arbiter2: scripted vector table, watchdog/reset sequences, and
// randomized traffic compared against a transaction-level model of the arbiter.
module tb_m_wb_arbiter2;

    localparam int          TIMEOUT = 64;
    localparam logic [31:0] TOVAL   = 32'hDEADBEEF;
    localparam logic [31:0] RDATA   = 32'h12345678;

    logic        clk;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_dout, m1_dout;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o;
    logic [3:0]  sel_o;
    logic        ack_i;
    logic [31:0] dat_i;
    logic [1:0]  gnt;
    logic        timeout;

    int n_chk = 0;
    int n_err = 0;

    m_wb_arbiter2 #(.TIMEOUT(TIMEOUT), .TOVAL(TOVAL), .TOW(7)) dut (
        .CLK_I(clk), .RST_I(rst),
        .M0_CYC_I(m0_cyc), .M0_STB_I(m0_stb), .M0_WE_I(m0_we),
        .M0_ADR_I(m0_adr), .M0_DAT_I(m0_dat), .M0_SEL_I(m0_sel),
        .M0_ACK_O(m0_ack), .M0_DAT_O(m0_dout),
        .M1_CYC_I(m1_cyc), .M1_STB_I(m1_stb), .M1_WE_I(m1_we),
        .M1_ADR_I(m1_adr), .M1_DAT_I(m1_dat), .M1_SEL_I(m1_sel),
        .M1_ACK_O(m1_ack), .M1_DAT_O(m1_dout),
        .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o),
        .ADR_O(adr_o), .DAT_O(dat_o), .SEL_O(sel_o),
        .ACK_I(ack_i), .DAT_I(dat_i),
        .gnt(gnt), .timeout(timeout)
    );

    // ---------------- clock / global time limit ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL time_limit: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: 0 = nobody, 1 = master 0, 2 = master 1; last: index of previous owner.
    int         m_owner = 0;
    int         m_last  = 1;
    int         m_wait  = 0;
    logic       m_stb, m_to;
    logic [1:0] exp_q[$];

    task automatic model_eval(input bit do_chk);
        logic        own0, own1;
        logic [70:0] bus;
        own0  = (m_owner == 1);
        own1  = (m_owner == 2);
        m_stb = own0 ? m0_stb : (own1 ? m1_stb : 1'b0);
        m_to  = m_stb && !ack_i && (TIMEOUT != 0) && (m_wait == TIMEOUT);
        if (own0)      bus = {m0_cyc, m_stb & ~m_to, m0_we, m0_sel, m0_adr, m0_dat};
        else if (own1) bus = {m1_cyc, m_stb & ~m_to, m1_we, m1_sel, m1_adr, m1_dat};
        else           bus = '0;
        if (do_chk) begin
            chk("rnd_gnt", 80'(gnt), 80'({own1, own0}));
            chk("rnd_bus", 80'({cyc_o, stb_o, we_o, sel_o, adr_o, dat_o}), 80'(bus));
            chk("rnd_ack0", 80'(m0_ack), 80'(own0 & (ack_i | m_to)));
            chk("rnd_ack1", 80'(m1_ack), 80'(own1 & (ack_i | m_to)));
            chk("rnd_dat0", 80'(m0_dout), 80'(own0 ? (m_to ? TOVAL : dat_i) : 32'h0));
            chk("rnd_dat1", 80'(m1_dout), 80'(own1 ? (m_to ? TOVAL : dat_i) : 32'h0));
            chk("rnd_timeout", 80'(timeout), 80'(m_to));
        end
    endtask

    task automatic model_step();
        int nxt;
        if (rst) begin
            m_owner = 0;
            m_last  = 1;
            m_wait  = 0;
            return;
        end
        nxt = m_owner;
        if (m_owner == 0) begin
            if (m0_cyc && m1_cyc) nxt = (1 - m_last) + 1;
            else if (m0_cyc)      nxt = 1;
            else if (m1_cyc)      nxt = 2;
        end else if (m_owner == 1 && !m0_cyc) begin
            m_last = 0;
            nxt    = m1_cyc ? 2 : 0;
        end else if (m_owner == 2 && !m1_cyc) begin
            m_last = 1;
            nxt    = m0_cyc ? 1 : 0;
        end
        if (nxt != m_owner) begin
            m_wait = 0;
            if (nxt != 0) exp_q.push_back(nxt == 1 ? 2'b01 : 2'b10);
        end else if (m_stb && !ack_i && !m_to) begin
            if (m_wait < 127) m_wait = m_wait + 1;
        end else begin
            m_wait = 0;
        end
        m_owner = nxt;
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input bit do_chk);
        model_eval(do_chk);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_m(input logic r, input logic c0, input logic s0,
                         input logic c1, input logic s1, input logic a);
        rst = r; m0_cyc = c0; m0_stb = s0; m1_cyc = c1; m1_stb = s1; ack_i = a;
        #2;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst, c0, s0, c1, s1, ack;
        logic [1:0] gnt;
        logic       a0, a1;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(input logic r, input logic c0, input logic s0, input logic c1,
                                input logic s1, input logic a, input logic [1:0] g,
                                input logic a0, input logic a1);
        vec_t v;
        v.rst = r; v.c0 = c0; v.s0 = s0; v.c1 = c1; v.s1 = s1; v.ack = a;
        v.gnt = g; v.a0 = a0; v.a1 = a1;
        return v;
    endfunction

    int         ack_mode;
    logic [1:0] prev_gnt;

    initial begin
        // single read by M0
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        tbl[1]  = mk(0, 1, 1, 0, 0, 0, 2'b00, 0, 0);
        tbl[2]  = mk(0, 1, 1, 0, 0, 1, 2'b01, 1, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        // ties from reset: M0, M1, M0 with direct handover
        tbl[5]  = mk(1, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        tbl[6]  = mk(0, 1, 1, 1, 1, 0, 2'b00, 0, 0);
        tbl[7]  = mk(0, 1, 1, 1, 1, 1, 2'b01, 1, 0);
        tbl[8]  = mk(0, 0, 0, 1, 1, 0, 2'b01, 0, 0);
        tbl[9]  = mk(0, 1, 1, 1, 1, 1, 2'b10, 0, 1);
        tbl[10] = mk(0, 1, 1, 0, 0, 0, 2'b10, 0, 0);
        tbl[11] = mk(0, 1, 1, 0, 0, 1, 2'b01, 1, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        // M1 locked 3-beat RMW, M0 waiting from beat 1
        tbl[14] = mk(0, 0, 0, 1, 1, 0, 2'b00, 0, 0);
        tbl[15] = mk(0, 1, 1, 1, 1, 1, 2'b10, 0, 1);
        tbl[16] = mk(0, 1, 1, 1, 0, 0, 2'b10, 0, 0);
        tbl[17] = mk(0, 1, 1, 1, 1, 1, 2'b10, 0, 1);
        tbl[18] = mk(0, 1, 1, 1, 1, 1, 2'b10, 0, 1);
        tbl[19] = mk(0, 1, 1, 0, 0, 0, 2'b10, 0, 0);
        tbl[20] = mk(0, 1, 1, 0, 0, 1, 2'b01, 1, 0);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 2'b01, 0, 0);
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);

        rst = 1'b1; ack_i = 1'b0; dat_i = RDATA;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 32'h0000_0100; m0_dat = 32'h0; m0_sel = 4'hF;
        m1_cyc = 0; m1_stb = 0; m1_we = 1; m1_adr = 32'h0000_0200; m1_dat = 32'hA5A5_0001; m1_sel = 4'h3;
        @(posedge clk);
        model_step();
        #1;

        for (int i = 0; i < 23; i++) begin
            set_m(tbl[i].rst, tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1, tbl[i].ack);
            chk($sformatf("tbl%0d_gnt", i), 80'(gnt), 80'(tbl[i].gnt));
            chk($sformatf("tbl%0d_ack0", i), 80'(m0_ack), 80'(tbl[i].a0));
            chk($sformatf("tbl%0d_ack1", i), 80'(m1_ack), 80'(tbl[i].a1));
            chk($sformatf("tbl%0d_dat0", i), 80'(m0_dout), 80'(tbl[i].gnt == 2'b01 ? RDATA : 32'h0));
            chk($sformatf("tbl%0d_dat1", i), 80'(m1_dout), 80'(tbl[i].gnt == 2'b10 ? RDATA : 32'h0));
            chk($sformatf("tbl%0d_cyc", i), 80'(cyc_o),
                80'(tbl[i].gnt == 2'b01 ? tbl[i].c0 : (tbl[i].gnt == 2'b10 ? tbl[i].c1 : 1'b0)));
            cycle(1'b0);
        end

        // watchdog: unmapped read by M0 never acknowledged
        m0_adr = 32'hF000_0000;
        set_m(0, 1, 1, 0, 0, 0);
        chk("wd_idle_gnt", 80'(gnt), 80'(2'b00));
        cycle(1'b0);
        for (int k = 0; k < TIMEOUT; k++) begin
            #2;
            chk($sformatf("wd_wait%0d", k), 80'({timeout, m0_ack, stb_o}), 80'(3'b001));
            cycle(1'b0);
        end
        #2;
        chk("wd_ack", 80'(m0_ack), 80'(1'b1));
        chk("wd_dat", 80'(m0_dout), 80'(TOVAL));
        chk("wd_pulse", 80'(timeout), 80'(1'b1));
        chk("wd_stb", 80'(stb_o), 80'(1'b0));
        cycle(1'b0);
        #2;
        chk("wd_clear", 80'({timeout, m0_ack, stb_o}), 80'(3'b001));
        cycle(1'b0);
        set_m(0, 0, 0, 0, 0, 0);
        cycle(1'b0);
        cycle(1'b0);

        // slave answering exactly as the counter reaches TIMEOUT
        set_m(0, 1, 1, 0, 0, 0);
        cycle(1'b0);
        for (int k = 0; k < TIMEOUT; k++) begin
            #2;
            chk($sformatf("lat_wait%0d", k), 80'({timeout, m0_ack, stb_o}), 80'(3'b001));
            cycle(1'b0);
        end
        dat_i = 32'hCAFE_F00D;
        set_m(0, 1, 1, 0, 0, 1);
        chk("lat_ack", 80'({timeout, m0_ack, stb_o}), 80'(3'b011));
        chk("lat_dat", 80'(m0_dout), 80'(32'hCAFE_F00D));
        cycle(1'b0);
        set_m(0, 0, 0, 0, 0, 0);
        cycle(1'b0);
        cycle(1'b0);

        // reset while M1 owns the bus mid-strobe
        set_m(0, 0, 0, 1, 1, 0);
        cycle(1'b0);
        #2;
        chk("rst_pre_gnt", 80'(gnt), 80'(2'b10));
        chk("rst_pre_stb", 80'(stb_o), 80'(1'b1));
        cycle(1'b0);
        set_m(1, 0, 0, 1, 1, 1);
        cycle(1'b0);
        set_m(0, 1, 1, 1, 1, 1);
        chk("rst_gnt", 80'(gnt), 80'(2'b00));
        chk("rst_cyc", 80'(cyc_o), 80'(1'b0));
        chk("rst_ack1", 80'(m1_ack), 80'(1'b0));
        cycle(1'b0);
        #2;
        chk("rst_tie_gnt", 80'(gnt), 80'(2'b01));
        set_m(0, 0, 0, 0, 0, 0);
        cycle(1'b0);
        cycle(1'b0);

        // randomized traffic against the model, grant order through exp_q
        exp_q.delete();
        prev_gnt = gnt;
        ack_mode = 0;
        for (int n = 0; n < 4000; n++) begin
            if (n % 150 == 0) ack_mode = $urandom_range(0, 2);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, (ack_mode == 1) ? 99 : 5) == 0) m0_cyc = ~m0_cyc;
            if ($urandom_range(0, (ack_mode == 1) ? 99 : 5) == 0) m1_cyc = ~m1_cyc;
            m0_stb = m0_cyc && (ack_mode == 1 || $urandom_range(0, 2) != 0);
            m1_stb = m1_cyc && (ack_mode == 1 || $urandom_range(0, 2) != 0);
            m0_we  = $urandom_range(0, 1) == 1;
            m1_we  = $urandom_range(0, 1) == 1;
            m0_adr = $urandom; m0_dat = $urandom; m0_sel = 4'($urandom_range(0, 15));
            m1_adr = $urandom; m1_dat = $urandom; m1_sel = 4'($urandom_range(0, 15));
            dat_i  = $urandom;
            case (ack_mode)
                0:       ack_i = $urandom_range(0, 1) == 1;
                1:       ack_i = 1'b0;
                default: ack_i = $urandom_range(0, 39) == 0;
            endcase
            #2;
            cycle(1'b1);
            if (gnt != prev_gnt && gnt != 2'b00) begin
                if (exp_q.size() == 0) chk("gnt_order", 80'(gnt), 80'(2'b00));
                else                   chk("gnt_order", 80'(gnt), 80'(exp_q.pop_front()));
            end
            prev_gnt = gnt;
        end
        chk("gnt_order_left", 80'(exp_q.size()), 80'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
